// File: rtl/mux_share_arbiter_if.sv
// mux_share_arbiter_if: request/grant/data bundle for the shared 2:1 select path
// master: requesters (drive req_*/data_*, observe grants and result)
// slave : arbiter (observe req_*/data_*, drive grant_*, sel, out, out_valid)
interface mux_share_arbiter_if #(parameter int WIDTH = 3);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             grant_a;
    logic             grant_b;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    modport master(output req_a, req_b, data_a, data_b, input grant_a, grant_b, sel, out, out_valid);
    modport slave(input req_a, req_b, data_a, data_b, output grant_a, grant_b, sel, out, out_valid);
endinterface

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin, hold-limited arbiter driving a shared 2:1 select path
// clk, rst (async, active high)
// bus.req_a/req_b, bus.data_a/data_b : requests and source data
// bus.grant_a/grant_b/sel            : registered grant decode, sel = grant_b
// bus.out/out_valid                  : data captured under the previous cycle's grant
module mux_share_arbiter #(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 4
) (
    input logic                clk,
    input logic                rst,
    mux_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;
    localparam logic [3:0] LIMIT = 4'(MAX_HOLD - 1);

    logic [1:0] state;
    logic [1:0] nxt;
    logic [1:0] idle_nxt;
    logic [1:0] a_nxt;
    logic [1:0] b_nxt;
    logic [3:0] cnt;
    logic       last_b;
    logic       contested;
    logic       busy;

    // last_b set means B was served last, so A wins a tie
    assign idle_nxt  = (bus.req_a && bus.req_b) ? (last_b ? GNT_A : GNT_B) :
                       bus.req_a ? GNT_A : bus.req_b ? GNT_B : IDLE;
    assign a_nxt     = !bus.req_a ? (bus.req_b ? GNT_B : IDLE) :
                       (bus.req_b && cnt == LIMIT) ? GNT_B : GNT_A;
    assign b_nxt     = !bus.req_b ? (bus.req_a ? GNT_A : IDLE) :
                       (bus.req_a && cnt == LIMIT) ? GNT_A : GNT_B;
    assign nxt       = state == GNT_A ? a_nxt : state == GNT_B ? b_nxt : idle_nxt;
    assign contested = (state == GNT_A && bus.req_b) || (state == GNT_B && bus.req_a);
    assign busy      = state == GNT_A || state == GNT_B;

    assign bus.grant_a = state == GNT_A;
    assign bus.grant_b = state == GNT_B;
    assign bus.sel     = state == GNT_B;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_b        <= 1'b1;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= nxt;
            // an uncontested owner keeps its count, so it is never forced off
            cnt           <= nxt != state ? 4'd0 : contested ? cnt + 4'd1 : cnt;
            if (nxt != state && nxt != IDLE)
                last_b <= nxt == GNT_B;
            bus.out_valid <= busy;
            if (busy)
                bus.out <= bus.sel ? bus.data_b : bus.data_a;
        end
    end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed stimulus with a per-cycle behavioural model check
module tb_mux_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;

    mux_share_arbiter_if #(.WIDTH(3)) bus();
    mux_share_arbiter_if #(.WIDTH(3)) bus1();

    mux_share_arbiter #(.WIDTH(3), .MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    mux_share_arbiter #(.WIDTH(3), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // model: owner 0 = nobody, 1 = A, 2 = B; run = contested cycles in current grant
    int       m_owner = 0;
    int       m_run = 0;
    int       m_last = 2;
    logic [2:0] m_out = 3'd0;
    bit       m_valid = 1'b0;
    int       n_owner;
    bit       mine;
    bit       other;
    int       other_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_run = 0; m_last = 2; m_out = 3'd0; m_valid = 1'b0;
        end else begin
            m_valid = m_owner != 0;
            if (m_owner != 0) m_out = (m_owner == 2) ? bus.data_b : bus.data_a;
            if (m_owner == 0) begin
                n_owner = (bus.req_a && bus.req_b) ? (m_last == 2 ? 1 : 2) :
                          bus.req_a ? 1 : bus.req_b ? 2 : 0;
                other = 1'b0;
            end else begin
                mine = (m_owner == 1) ? bus.req_a : bus.req_b;
                other = (m_owner == 1) ? bus.req_b : bus.req_a;
                other_id = 3 - m_owner;
                if (!mine) n_owner = other ? other_id : 0;
                else if (other && m_run + 1 >= 4) n_owner = other_id;
                else n_owner = m_owner;
            end
            if (n_owner != m_owner) m_run = 0;
            else if (other) m_run++;
            if (n_owner != 0 && n_owner != m_owner) m_last = n_owner;
            m_owner = n_owner;
        end
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("grant_a", bus.grant_a, m_owner == 1);
        chk("grant_b", bus.grant_b, m_owner == 2);
        chk("sel", bus.sel, m_owner == 2);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out", bus.out, m_out);
        chk("one_hot", bus.grant_a & bus.grant_b, 0);
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.data_a = 0; bus.data_b = 0;
        bus1.req_a = 0; bus1.req_b = 0; bus1.data_a = 3'd1; bus1.data_b = 3'd2;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("idle_grant_a", bus.grant_a, 0);
            chk("idle_grant_b", bus.grant_b, 0);
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_out", bus.out, 0);
        end
        bus.req_a = 1; bus.data_a = 3'b101;
        step(1);
        chk("single_grant_a", bus.grant_a, 1);
        chk("single_sel", bus.sel, 0);
        chk("single_valid_lag", bus.out_valid, 0);
        step(1);
        chk("single_out", bus.out, 5);
        chk("single_valid", bus.out_valid, 1);
        bus.req_a = 0;
        step(1);
        chk("drop_grant_a", bus.grant_a, 0);
        chk("drop_valid_tail", bus.out_valid, 1);
        step(1);
        chk("drop_valid", bus.out_valid, 0);
        chk("drop_out_hold", bus.out, 5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.data_a = 3'b010; bus.data_b = 3'b110; bus.req_a = 1; bus.req_b = 1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("tie_grant_a", bus.grant_a, (k <= 4 || k == 9));
            chk("tie_grant_b", bus.grant_b, (k >= 5 && k <= 8));
            chk("tie_sel", bus.sel, (k >= 5 && k <= 8));
            if (k == 1) chk("model_tie_owner", m_owner, 1);
            if (k == 5) chk("tie_out_a", bus.out, 2);
            if (k == 6) chk("tie_out_b", bus.out, 6);
            if (k == 5) chk("model_switch_owner", m_owner, 2);
        end
        bus.req_a = 0; bus.req_b = 0;
        step(1);
        chk("both_drop_a", bus.grant_a, 0);
        chk("both_drop_b", bus.grant_b, 0);
        step(1);
        chk("both_drop_valid", bus.out_valid, 0);
        bus.req_b = 1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("uncontested_b", bus.grant_b, 1);
        end
        bus.req_a = 1; bus.req_b = 0; bus.data_a = 3'd3; bus.data_b = 3'd4;
        step(1);
        chk("release_to_a", bus.grant_a, 1);
        bus.req_a = 0; bus.req_b = 1;
        step(1);
        chk("handover_b", bus.grant_b, 1);
        chk("handover_a_off", bus.grant_a, 0);
        chk("handover_out_a", bus.out, 3);
        step(1);
        chk("handover_out_b", bus.out, 4);
        chk("handover_valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_grant_b", bus.grant_b, 0);
        chk("async_sel", bus.sel, 0);
        chk("async_out", bus.out, 0);
        chk("async_valid", bus.out_valid, 0);
        bus.req_a = 1; bus.req_b = 1; bus1.req_a = 1; bus1.req_b = 1;
        #1 rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 1) chk("post_reset_tie_a", bus.grant_a, 1);
            chk("hold1_grant_a", bus1.grant_a, k % 2);
            chk("hold1_grant_b", bus1.grant_b, 1 - k % 2);
        end
        bus.req_a = 0; bus.req_b = 0; bus1.req_a = 0; bus1.req_b = 0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Arbiter and sequencer for the shared 3-bit 2:1 select datapath (sel=0 passes source A, sel=1 passes source B).
- Two requesters each present 3-bit data plus a request line.
- The block grants the path to one requester at a time using round-robin priority and a hold limit.
- It drives sel and produces a registered, valid-qualified 3-bit result for downstream logic such as display or sequencing blocks.

Parameters:
- WIDTH, 3: data width of each source and of out.
- MAX_HOLD, 4: maximum consecutive granted cycles while the other requester is waiting. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A wants the path; held high while it needs it.
- req_b  input  1  requester B wants the path.
- data_a  input  WIDTH  requester A data.
- data_b  input  WIDTH  requester B data.
- grant_a  output  1  A owns the path (registered).
- grant_b  output  1  B owns the path (registered).
- sel  output  1  mux select: 1 when grant_b, else 0.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out holds data captured under a grant in the previous cycle.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - grant_a = grant_b = sel = 0.
  - out = 0, out_valid = 0.
  - Hold counter = 0.
  - last_served = B, so A wins the first tie.
- States: IDLE, GNT_A, GNT_B. All transitions occur on the rising edge of clk.
- IDLE:
  - Only req_a -> GNT_A.
  - Only req_b -> GNT_B.
  - Both -> the requester not equal to last_served.
  - Neither -> stay in IDLE.
- GNT_A:
  - req_a = 0: go to GNT_B if req_b, else IDLE.
  - req_a = 1, req_b = 1, hold counter = MAX_HOLD-1 -> forced switch to GNT_B.
  - Otherwise stay in GNT_A.
- GNT_B: symmetric to GNT_A.
- last_served updates on entry to a grant state.
- Hold counter:
  - Clears on every state change.
  - Increments each cycle in a grant state while the other requester is asserting.
  - Holds its value while the other requester is idle, so an uncontested owner keeps the path indefinitely.
- Outputs:
  - grant_a, grant_b and sel decode directly from state registers. No glitching combinational path from req.
  - At most one grant is high in any cycle.
- Latency: req rises before edge n -> grant high after edge n. Handover between requesters takes zero idle cycles.
- Data path:
  - On each edge where a grant is high, out <= (sel ? data_b : data_a) and out_valid <= 1.
  - On an edge with no grant, out holds its last value and out_valid <= 0.
  - out therefore lags grant by one cycle.
- Boundary conditions:
  - A req dropping in the same cycle as a forced switch is treated as a release; the resulting next state is the same.
  - Both requests dropping -> IDLE next edge.
  - Reset asserted mid-grant clears everything immediately. After release, the first tie goes to A.
  - With MAX_HOLD = 1 and both requesting continuously, grants alternate every cycle.

Test Plan:
- Reset then idle:
  - Hold rst 3 cycles, release, no requests -> all outputs 0 for 5 cycles.
- Single requester:
  - req_a = 1, data_a = 3'b101 -> grant_a = 1 and sel = 0 after next edge.
  - One edge later, out = 101 and out_valid = 1.
  - Drop req_a -> grant_a = 0 next edge, out_valid = 0 the edge after, out stays 101.
- Tie from reset:
  - req_a = req_b = 1 simultaneously -> grant_a first.
  - Forced switch to grant_b after exactly 4 cycles (MAX_HOLD = 4).
  - Then back to grant_a after 4 more. sel toggles accordingly; out follows data_a = 010 and data_b = 110.
- Uncontested hold:
  - req_b alone for 20 cycles -> grant_b stays high throughout; no forced switch.
- Release handover:
  - In GNT_A, deassert req_a while req_b = 1 -> grant_b high on the very next edge with no IDLE cycle.
  - out shows data_b one edge later.
- Async reset mid-grant:
  - Assert rst between clock edges while grant_b = 1 -> all outputs 0 immediately, without waiting for a clock edge.
  - After release with both requests high, grant_a wins.
